id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 tb/tb_id_ex_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use interlock, hold/flush and a bubble counter.
// Ports: clk, reset, id_* bundle in, hold, flush; ID_EX_* bundle out, pc_write, if_id_write, stall_active, stall_count.
module id_ex_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [2:0]    id_rm_1,
  input  logic [2:0]    id_rd_11,
  input  logic [2:0]    id_rd_12,
  input  logic          id_ALUSrcB,
  input  logic [2:0]    id_wd_1,
  input  logic [2:0]    id_wd_2,
  input  logic          id_RegWrite1,
  input  logic          id_MemRead1,
  input  logic          id_RegWrite2,
  input  logic [2:0]    id_rm_2,
  input  logic [2:0]    id_rn_2,
  input  logic [2:0]    id_rd_2,
  input  logic [DW-1:0] id_imm,
  input  logic          hold,
  input  logic          flush,
  output logic          ID_EX_valid,
  output logic [2:0]    ID_EX_rm_1,
  output logic [2:0]    ID_EX_rd_11,
  output logic [2:0]    ID_EX_rd_12,
  output logic          ID_EX_ALUSrcB,
  output logic [2:0]    ID_EX_wd_1,
  output logic [2:0]    ID_EX_wd_2,
  output logic          ID_EX_RegWrite1,
  output logic          ID_EX_MemRead1,
  output logic          ID_EX_RegWrite2,
  output logic [2:0]    ID_EX_rm_2,
  output logic [2:0]    ID_EX_rn_2,
  output logic [2:0]    ID_EX_rd_2,
  output logic [DW-1:0] ID_EX_imm,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          stall_active,
  output logic [15:0]   stall_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t state;

  logic [2:0] src_b;
  logic       hit;
  logic       hazard;
  logic       advance;
  logic       bubble;

  assign src_b = id_ALUSrcB ? id_rd_12 : id_rd_11;

  assign hit = (ID_EX_wd_1 == id_rm_1)
             | (ID_EX_wd_1 == src_b)
             | (ID_EX_wd_1 == id_rm_2)
             | (ID_EX_wd_1 == id_rn_2)
             | (ID_EX_wd_1 == id_rd_2);

  // r0 is never a real producer, and STALL masks a repeat detection.
  assign hazard = (state == RUN)
                & ID_EX_valid
                & ID_EX_MemRead1
                & (ID_EX_wd_1 != 3'd0)
                & id_valid
                & hit;

  // Flush wins over a coincident hazard, so the front end still advances.
  assign advance     = ~reset & ~hold & (flush | ~hazard);
  assign pc_write    = advance;
  assign if_id_write = advance;

  assign bubble = flush | hazard | ~id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      stall_active    <= 1'b0;
      stall_count     <= 16'd0;
      ID_EX_valid     <= 1'b0;
      ID_EX_rm_1      <= 3'd0;
      ID_EX_rd_11     <= 3'd0;
      ID_EX_rd_12     <= 3'd0;
      ID_EX_ALUSrcB   <= 1'b0;
      ID_EX_wd_1      <= 3'd0;
      ID_EX_wd_2      <= 3'd0;
      ID_EX_RegWrite1 <= 1'b0;
      ID_EX_MemRead1  <= 1'b0;
      ID_EX_RegWrite2 <= 1'b0;
      ID_EX_rm_2      <= 3'd0;
      ID_EX_rn_2      <= 3'd0;
      ID_EX_rd_2      <= 3'd0;
      ID_EX_imm       <= '0;
    end else if (!hold) begin
      if (bubble) begin
        ID_EX_valid     <= 1'b0;
        ID_EX_rm_1      <= 3'd0;
        ID_EX_rd_11     <= 3'd0;
        ID_EX_rd_12     <= 3'd0;
        ID_EX_ALUSrcB   <= 1'b0;
        ID_EX_wd_1      <= 3'd0;
        ID_EX_wd_2      <= 3'd0;
        ID_EX_RegWrite1 <= 1'b0;
        ID_EX_MemRead1  <= 1'b0;
        ID_EX_RegWrite2 <= 1'b0;
        ID_EX_rm_2      <= 3'd0;
        ID_EX_rn_2      <= 3'd0;
        ID_EX_rd_2      <= 3'd0;
        ID_EX_imm       <= '0;
      end else begin
        ID_EX_valid     <= 1'b1;
        ID_EX_rm_1      <= id_rm_1;
        ID_EX_rd_11     <= id_rd_11;
        ID_EX_rd_12     <= id_rd_12;
        ID_EX_ALUSrcB   <= id_ALUSrcB;
        ID_EX_wd_1      <= id_wd_1;
        ID_EX_wd_2      <= id_wd_2;
        ID_EX_RegWrite1 <= id_RegWrite1;
        ID_EX_MemRead1  <= id_MemRead1;
        ID_EX_RegWrite2 <= id_RegWrite2;
        ID_EX_rm_2      <= id_rm_2;
        ID_EX_rn_2      <= id_rn_2;
        ID_EX_rd_2      <= id_rd_2;
        ID_EX_imm       <= id_imm;
      end

      if (hazard && !flush) begin
        state        <= STALL;
        stall_active <= 1'b1;
        if (stall_count != 16'hFFFF)
          stall_count <= stall_count + 16'd1;
      end else begin
        state        <= RUN;
        stall_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes model predictions, monitor pops and compares.
// Directed load-use, r0, ALUSrcB, flush, hold, reset and saturation cases plus random traffic.
module tb_id_ex_stage;

  localparam int DW = 16;

  typedef struct packed {
    logic          valid;
    logic [2:0]    rm_1;
    logic [2:0]    rd_11;
    logic [2:0]    rd_12;
    logic          srcb;
    logic [2:0]    wd_1;
    logic [2:0]    wd_2;
    logic          rw1;
    logic          mr1;
    logic          rw2;
    logic [2:0]    rm_2;
    logic [2:0]    rn_2;
    logic [2:0]    rd_2;
    logic [DW-1:0] imm;
  } bund_t;

  typedef struct {
    bund_t ex;
    bit    pc;
    bit    st;
    int    cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold_i;
  logic        flush_i;
  bund_t       in_b;
  bund_t       out_b;
  logic        ID_EX_valid;
  logic [2:0]  ID_EX_rm_1;
  logic [2:0]  ID_EX_rd_11;
  logic [2:0]  ID_EX_rd_12;
  logic        ID_EX_ALUSrcB;
  logic [2:0]  ID_EX_wd_1;
  logic [2:0]  ID_EX_wd_2;
  logic        ID_EX_RegWrite1;
  logic        ID_EX_MemRead1;
  logic        ID_EX_RegWrite2;
  logic [2:0]  ID_EX_rm_2;
  logic [2:0]  ID_EX_rn_2;
  logic [2:0]  ID_EX_rd_2;
  logic [DW-1:0] ID_EX_imm;
  logic        pc_write;
  logic        if_id_write;
  logic        stall_active;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (in_b.valid),
    .id_rm_1        (in_b.rm_1),
    .id_rd_11       (in_b.rd_11),
    .id_rd_12       (in_b.rd_12),
    .id_ALUSrcB     (in_b.srcb),
    .id_wd_1        (in_b.wd_1),
    .id_wd_2        (in_b.wd_2),
    .id_RegWrite1   (in_b.rw1),
    .id_MemRead1    (in_b.mr1),
    .id_RegWrite2   (in_b.rw2),
    .id_rm_2        (in_b.rm_2),
    .id_rn_2        (in_b.rn_2),
    .id_rd_2        (in_b.rd_2),
    .id_imm         (in_b.imm),
    .hold           (hold_i),
    .flush          (flush_i),
    .ID_EX_valid    (ID_EX_valid),
    .ID_EX_rm_1     (ID_EX_rm_1),
    .ID_EX_rd_11    (ID_EX_rd_11),
    .ID_EX_rd_12    (ID_EX_rd_12),
    .ID_EX_ALUSrcB  (ID_EX_ALUSrcB),
    .ID_EX_wd_1     (ID_EX_wd_1),
    .ID_EX_wd_2     (ID_EX_wd_2),
    .ID_EX_RegWrite1(ID_EX_RegWrite1),
    .ID_EX_MemRead1 (ID_EX_MemRead1),
    .ID_EX_RegWrite2(ID_EX_RegWrite2),
    .ID_EX_rm_2     (ID_EX_rm_2),
    .ID_EX_rn_2     (ID_EX_rn_2),
    .ID_EX_rd_2     (ID_EX_rd_2),
    .ID_EX_imm      (ID_EX_imm),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .stall_active   (stall_active),
    .stall_count    (stall_count)
  );

  assign out_b = {ID_EX_valid, ID_EX_rm_1, ID_EX_rd_11, ID_EX_rd_12,
                  ID_EX_ALUSrcB, ID_EX_wd_1, ID_EX_wd_2, ID_EX_RegWrite1,
                  ID_EX_MemRead1, ID_EX_RegWrite2, ID_EX_rm_2, ID_EX_rn_2,
                  ID_EX_rd_2, ID_EX_imm};

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q[$];

  // Reference model state: what EX holds, whether we are in the bubble cycle, bubble count.
  bund_t m_ex;
  bit    m_stall;
  int    m_cnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  function automatic bit uses(bund_t ex, bund_t i, bit st);
    logic [2:0] srcs[5];
    bit hit;
    srcs = '{i.rm_1, (i.srcb ? i.rd_12 : i.rd_11), i.rm_2, i.rn_2, i.rd_2};
    hit = 0;
    foreach (srcs[k]) if (srcs[k] == ex.wd_1) hit = 1;
    return !st && ex.valid && ex.mr1 && ex.wd_1 != 0 && i.valid && hit;
  endfunction

  task automatic step(bund_t b, bit h, bit f);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    in_b = b;
    hold_i = h;
    flush_i = f;
    hz = uses(m_ex, b, m_stall);
    e.ex = m_ex;
    e.st = m_stall;
    e.cnt = m_cnt;
    e.pc = !h && (f || !hz);
    q.push_back(e);
    if (!h) begin
      if (f) begin
        m_ex = '0;
        m_stall = 0;
      end else if (hz) begin
        m_ex = '0;
        m_stall = 1;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
        m_ex = b.valid ? b : '0;
        m_stall = 0;
      end
    end
  endtask

  task automatic pc_now(string name, bit req);
    #1;
    chk(name, 64'(pc_write), 64'(req));
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_ex"}, 64'(out_b), 64'd0);
    chk({tag, "_pc"}, 64'(pc_write), 64'd0);
    chk({tag, "_ifid"}, 64'(if_id_write), 64'd0);
    chk({tag, "_stall"}, 64'(stall_active), 64'd0);
    chk({tag, "_cnt"}, 64'(stall_count), 64'd0);
  endtask

  // Reset lands mid-cycle, away from both edges.
  task automatic do_reset(string tag);
    @(posedge clk);
    #3;
    in_b = '0;
    hold_i = 0;
    flush_i = 0;
    reset = 1;
    #1;
    reset_checks(tag);
    #3;
    reset = 0;
    m_ex = '0;
    m_stall = 0;
    m_cnt = 0;
  endtask

  function automatic bund_t nop();
    bund_t b;
    b = '0;
    b.valid = 1;
    b.imm = DW'($urandom);
    return b;
  endfunction

  function automatic bund_t ld(logic [2:0] wd);
    bund_t b;
    b = nop();
    b.wd_1 = wd;
    b.mr1 = 1;
    b.rw1 = 1;
    return b;
  endfunction

  function automatic bund_t rnd();
    bund_t b;
    b.valid = ($urandom_range(0, 99) < 85);
    b.rm_1  = 3'($urandom_range(0, 3));
    b.rd_11 = 3'($urandom_range(0, 3));
    b.rd_12 = 3'($urandom_range(0, 3));
    b.srcb  = 1'($urandom);
    b.wd_1  = 3'($urandom_range(0, 3));
    b.wd_2  = 3'($urandom);
    b.rw1   = 1'($urandom);
    b.mr1   = 1'($urandom);
    b.rw2   = 1'($urandom);
    b.rm_2  = 3'($urandom_range(0, 7));
    b.rn_2  = 3'($urandom_range(0, 7));
    b.rd_2  = 3'($urandom_range(0, 7));
    b.imm   = DW'($urandom);
    return b;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_ex", 64'(out_b), 64'(e.ex));
        chk("sb_pc", 64'(pc_write), 64'(e.pc));
        chk("sb_ifid", 64'(if_id_write), 64'(e.pc));
        chk("sb_stall", 64'(stall_active), 64'(e.st));
        chk("sb_cnt", 64'(stall_count), 64'(e.cnt));
      end
    end
  end

  initial begin : driver
    bund_t u;
    int    c0;
    reset = 1;
    hold_i = 0;
    flush_i = 0;
    in_b = '0;
    m_ex = '0;
    m_stall = 0;
    m_cnt = 0;
    #3;
    reset_checks("rst0");
    #5;
    reset = 0;

    // Load-use on r3 through rm_1.
    step(ld(3'd3), 0, 0);
    pc_now("ldu_load_pc", 1);
    u = nop();
    u.rm_1 = 3'd3;
    step(u, 0, 0);
    pc_now("ldu_hz_pc", 0);
    step(u, 0, 0);
    pc_now("ldu_stall_pc", 1);
    step(nop(), 0, 0);
    @(negedge clk);
    chk("ldu_cnt", 64'(stall_count), 64'd1);
    chk("ldu_ex", 64'(out_b), 64'(u));

    // Load into r0 never stalls.
    c0 = m_cnt;
    step(ld(3'd0), 0, 0);
    u = nop();
    u.rm_2 = 3'd0;
    step(u, 0, 0);
    pc_now("r0_pc", 1);
    step(nop(), 0, 0);
    @(negedge clk);
    chk("r0_cnt", 64'(stall_count), 64'(c0));

    // Only the selected B operand matters.
    step(ld(3'd5), 0, 0);
    u = ld(3'd5);
    u.rd_11 = 3'd5;
    u.rd_12 = 3'd2;
    u.srcb = 1;
    step(u, 0, 0);
    pc_now("srcb1_pc", 1);
    u = nop();
    u.rd_11 = 3'd5;
    u.rd_12 = 3'd2;
    u.srcb = 0;
    step(u, 0, 0);
    pc_now("srcb0_pc", 0);
    step(u, 0, 0);

    // Flush beats a coincident hazard.
    c0 = m_cnt;
    step(ld(3'd3), 0, 0);
    u = nop();
    u.rm_1 = 3'd3;
    step(u, 0, 1);
    pc_now("flush_pc", 1);
    step(nop(), 0, 0);
    @(negedge clk);
    chk("flush_ex", 64'(out_b), 64'd0);
    chk("flush_st", 64'(stall_active), 64'd0);
    chk("flush_cnt", 64'(stall_count), 64'(c0));

    // Hold for three cycles while in STALL.
    step(ld(3'd4), 0, 0);
    u = nop();
    u.rn_2 = 3'd4;
    step(u, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(u, 1, 0);
      #1;
      chk("hold_st", 64'(stall_active), 64'd1);
      chk("hold_pc", 64'(pc_write), 64'd0);
    end
    step(u, 0, 0);
    pc_now("hold_rel_pc", 1);
    step(nop(), 0, 0);
    #1;
    chk("hold_run", 64'(stall_active), 64'd0);
    chk("hold_ex", 64'(out_b), 64'(u));

    // Reset in the middle of a STALL.
    step(ld(3'd6), 0, 0);
    u = nop();
    u.rd_2 = 3'd6;
    step(u, 0, 0);
    do_reset("rst_stall");
    step(u, 0, 0);
    pc_now("post_rst_pc", 1);
    step(nop(), 0, 0);
    #1;
    chk("post_rst_ex", 64'(out_b), 64'(u));

    // Random traffic with narrow register ranges so hazards are frequent.
    for (int k = 0; k < 400; k++)
      step(rnd(), ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 10));

    // Drive the counter to saturation with a self-dependent load.
    u = ld(3'd3);
    u.rm_1 = 3'd3;
    while (m_cnt < 65535) step(u, 0, 0);
    step(u, 0, 0);
    step(u, 0, 0);
    pc_now("sat_hz_pc", 0);
    step(nop(), 0, 0);
    @(negedge clk);
    chk("sat_cnt", 64'(stall_count), 64'hFFFF);
    do_reset("rst_sat");

    @(negedge clk);
    #1;
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
